// File: rtl/vga_capture_pkg.sv
// Shared types and constants for the VGA frame capture block.
package vga_capture_pkg;

  // Image RAM address width (covers a 256x256 window).
  localparam int ADDR_W = 18;

  // Width of the in-frame pixel and line counters.
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE,
    DONE
  } state_t;

  // Luma approximation (r + 2g + b) / 4, summed at 10 bits so nothing overflows.
  function automatic logic [7:0] to_gray(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
    logic [9:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[9:2];
  endfunction

endpackage

// File: rtl/vga_capture_sync_edge_detect.sv
// Falling-edge detection of the active-low VGA syncs, qualified by pix_en.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic pix_en,
  input  logic hsync,
  input  logic vsync,
  output logic hsync_fall,
  output logic vsync_fall
);

  logic hsync_prev;
  logic vsync_prev;

  // Remember the previous pixel-rate sample; idle-high so reset never fakes an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_prev <= 1'b1;
      vsync_prev <= 1'b1;
    end else if (pix_en) begin
      hsync_prev <= hsync;
      vsync_prev <= vsync;
    end
  end

  assign hsync_fall = pix_en & hsync_prev & ~hsync;
  assign vsync_fall = pix_en & vsync_prev & ~vsync;

endmodule

// File: rtl/vga_capture.sv
// Captures one windowed grayscale frame from a VGA pixel stream into image RAM.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int X_OFF = 0,
  parameter int Y_OFF = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_en,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              n_blank,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  input  logic              arm,
  output logic [ADDR_W-1:0] wr_address,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              frame_error
);

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  X_LO   = CNT_W'(X_OFF);
  localparam logic [CNT_W-1:0]  Y_LO   = CNT_W'(Y_OFF);

  state_t            state_reg;
  logic [CNT_W-1:0]  px_reg;
  logic [CNT_W-1:0]  ln_reg;
  logic              line_seen_reg;   // current line has had at least one active pixel

  logic              hsync_fall;
  logic              vsync_fall;
  logic              in_window;
  logic              pixel_write;
  logic              last_pixel;
  logic [CNT_W-1:0]  px_rel;
  logic [CNT_W-1:0]  ln_rel;
  logic [ADDR_W-1:0] addr_calc;

  sync_edge_detect u_sync_edge_detect (
    .clock      (clock),
    .reset      (reset),
    .pix_en     (pix_en),
    .hsync      (hsync),
    .vsync      (vsync),
    .hsync_fall (hsync_fall),
    .vsync_fall (vsync_fall)
  );

  // Window test and RAM address for the pixel being sampled this clock.
  always_comb begin
    in_window   = (int'(px_reg) >= X_OFF) && (int'(px_reg) < X_OFF + IMG_W) &&
                  (int'(ln_reg) >= Y_OFF) && (int'(ln_reg) < Y_OFF + IMG_H);
    pixel_write = (state_reg == CAPTURE) && pix_en && n_blank && in_window;
    px_rel      = px_reg - X_LO;
    ln_rel      = ln_reg - Y_LO;
    addr_calc   = ADDR_W'(ln_rel) * W_A + ADDR_W'(px_rel);
    last_pixel  = pixel_write && (addr_calc == LAST_A);
  end

  // Capture FSM with counters and registered RAM-side outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      px_reg        <= '0;
      ln_reg        <= '0;
      line_seen_reg <= 1'b0;
      wr_en         <= 1'b0;
      wr_address    <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      wr_en <= pixel_write;
      if (pixel_write) begin
        wr_address <= addr_calc;
        wr_data    <= to_gray(red, green, blue);
      end
      done <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg   <= WAIT_FRAME;
            busy        <= 1'b1;
            frame_error <= 1'b0;
          end
        end

        WAIT_FRAME: begin
          if (vsync_fall) begin
            state_reg     <= CAPTURE;
            px_reg        <= '0;
            ln_reg        <= '0;
            line_seen_reg <= 1'b0;
          end
        end

        CAPTURE: begin
          // A completed window wins even if vsync happens to fall on the same sample.
          if (last_pixel) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (vsync_fall) begin
            state_reg   <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            frame_error <= 1'b1;
          end

          // Vsync outranks hsync: counters are left alone on a vsync edge.
          if (!vsync_fall) begin
            if (hsync_fall) begin
              px_reg        <= '0;
              line_seen_reg <= 1'b0;
              if (line_seen_reg) begin
                ln_reg <= ln_reg + CNT_W'(1);
              end
            end else if (pix_en && n_blank) begin
              px_reg        <= px_reg + CNT_W'(1);
              line_seen_reg <= 1'b1;
            end
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: two windows driven by one shared VGA stream, scoreboarded writes.
module tb_vga_capture;

  localparam int W0 = 16, H0 = 8, XO0 = 0,  YO0 = 0;
  localparam int W1 = 4,  H1 = 2, XO1 = 10, YO1 = 5;
  localparam int ACT_W = 24;
  localparam int NVEC  = 8;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        n_blank = 1'b0;
  logic        arm = 1'b0;
  logic [7:0]  red = 8'd0, green = 8'd0, blue = 8'd0;

  logic [17:0] wr_address [2];
  logic [7:0]  wr_data [2];
  logic [1:0]  wr_en, busy, done, frame_error;

  int checks = 0;
  int errors = 0;
  int frame_no = 0;
  bit mon_on = 1'b0;

  int pw[2], ph[2], pxo[2], pyo[2];
  bit m_wait[2], m_cap[2], m_err[2];
  int exp_done[2], act_done[2], exp_wr[2], act_wr[2];
  logic [25:0] exp_q0[$];
  logic [25:0] exp_q1[$];
  logic [7:0]  got0[NVEC];
  vec_t        vecs[NVEC];

  always #10 clock = ~clock;

  vga_capture #(.IMG_W(W0), .IMG_H(H0), .X_OFF(XO0), .Y_OFF(YO0)) dut0 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .n_blank(n_blank), .red(red), .green(green), .blue(blue), .arm(arm),
    .wr_address(wr_address[0]), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
    .busy(busy[0]), .done(done[0]), .frame_error(frame_error[0])
  );

  vga_capture #(.IMG_W(W1), .IMG_H(H1), .X_OFF(XO1), .Y_OFF(YO1)) dut1 (
    .clock(clock), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .n_blank(n_blank), .red(red), .green(green), .blue(blue), .arm(arm),
    .wr_address(wr_address[1]), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
    .busy(busy[1]), .done(done[1]), .frame_error(frame_error[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int gray(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    return (int'(r) + 2 * int'(g) + int'(b)) / 4;
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Scoreboard: every DUT write must match the oldest expected {addr, data}.
  task automatic mon(input int i, input logic en, input logic [17:0] a,
                     input logic [7:0] d, input logic dn);
    logic [25:0] e;
    if (dn === 1'b1) act_done[i]++;
    if (en === 1'b1) begin
      act_wr[i]++;
      checks++;
      if (i == 0 && a < 18'(NVEC)) got0[a[2:0]] = d;
      if (q_size(i) == 0) begin
        errors++;
        $display("FAIL wr%0d unexpected write: got addr=%0d data=%0d, required no write", i, a, d);
      end else begin
        if (i == 0) e = exp_q0.pop_front();
        else        e = exp_q1.pop_front();
        if ({a, d} !== e) begin
          errors++;
          $display("FAIL wr%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   i, a, d, e[25:8], e[7:0]);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      for (int i = 0; i < 2; i++) mon(i, wr_en[i], wr_address[i], wr_data[i], done[i]);
    end
  end

  // Reference model: a raster pixel (x, y) lands in each capturing window it belongs to.
  task automatic model_pixel(input int x, input int y, input int gv);
    for (int i = 0; i < 2; i++) begin
      if (m_cap[i] && x >= pxo[i] && x < pxo[i] + pw[i] && y >= pyo[i] && y < pyo[i] + ph[i]) begin
        int a;
        a = (y - pyo[i]) * pw[i] + (x - pxo[i]);
        if (i == 0) exp_q0.push_back({18'(a), 8'(gv)});
        else        exp_q1.push_back({18'(a), 8'(gv)});
        exp_wr[i]++;
        if (a == pw[i] * ph[i] - 1) begin
          m_cap[i] = 1'b0;
          exp_done[i]++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      pix_en = 1'b0;
    end
  endtask

  // One pix_en sample, preceded by 0..2 non-qualified cycles carrying junk inputs.
  task automatic sample(input logic hs, input logic vs, input logic nb,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int gap = $urandom_range(2, 0);
    for (int k = 0; k < gap; k++) begin
      @(negedge clock);
      pix_en = 1'b0;
      hsync = 1'($urandom); vsync = 1'($urandom); n_blank = 1'($urandom);
      red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
    end
    @(negedge clock);
    pix_en = 1'b1; hsync = hs; vsync = vs; n_blank = nb;
    red = r; green = g; blue = b;
  endtask

  task automatic pulse_arm();
    @(negedge clock);
    pix_en = 1'b0;
    arm = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (!m_wait[i] && !m_cap[i]) begin
        m_wait[i] = 1'b1;
        m_err[i]  = 1'b0;
      end
    end
    @(negedge clock);
    arm = 1'b0;
    $display("arm: busy=%b%b frame_error=%b%b", busy[1], busy[0], frame_error[1], frame_error[0]);
  endtask

  // Pixel sample coinciding with reset: it must never be written.
  task automatic reset_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    @(negedge clock);
    pix_en = 1'b1; hsync = 1'b1; vsync = 1'b1; n_blank = 1'b1;
    red = r; green = g; blue = b;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pix_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_mid wr_en%0d", i), 32'(wr_en[i]), 32'd0);
      check($sformatf("rst_mid wr_address%0d", i), 32'(wr_address[i]), 32'd0);
      check($sformatf("rst_mid wr_data%0d", i), 32'(wr_data[i]), 32'd0);
      check($sformatf("rst_mid busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("rst_mid done%0d", i), 32'(done[i]), 32'd0);
      m_wait[i] = 1'b0; m_cap[i] = 1'b0; m_err[i] = 1'b0;
    end
    $display("reset mid-capture applied");
  endtask

  // Hsync and vsync fall together here, so the vsync rule is what must act.
  task automatic drive_vsync();
    sample(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      if (m_cap[i]) begin
        m_cap[i] = 1'b0;
        m_err[i] = 1'b1;
        exp_done[i]++;
      end else if (m_wait[i]) begin
        m_wait[i] = 1'b0;
        m_cap[i]  = 1'b1;
      end
    end
    sample(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  // mode 0: random colour, 1: (px, ln, 0), 2: table vectors on the first active pixels
  task automatic drive_line(input int y, input bit active, input int mode, input bit do_rst);
    sample(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int x = 0; x < ACT_W; x++) begin
      logic [7:0] r, g, b;
      int gv;
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      if (mode == 1) begin
        r = 8'(x); g = 8'(y); b = 8'd0;
      end
      gv = gray(r, g, b);
      if (mode == 2 && y == 0 && x < NVEC) begin
        r = vecs[x].r; g = vecs[x].g; b = vecs[x].b;
        gv = int'(vecs[x].exp);
      end
      if (do_rst && x == 5) begin
        reset_pixel(r, g, b);
      end else begin
        sample(1'b1, 1'b1, active, r, g, b);
        if (active) model_pixel(x, y, gv);
      end
    end
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    sample(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic drive_frame(input int nlines, input int mode, input int arm_line, input int rst_line);
    drive_vsync();
    drive_line(-1, 1'b0, mode, 1'b0);
    drive_line(-1, 1'b0, mode, 1'b0);
    for (int y = 0; y < nlines; y++) begin
      if (y == arm_line) pulse_arm();
      drive_line(y, 1'b1, mode, y == rst_line);
    end
    idle(2);
    frame_no++;
    $display("frame %0d: lines=%0d mode=%0d writes=%0d/%0d done=%0d/%0d",
             frame_no, nlines, mode, act_wr[0], act_wr[1], act_done[0], act_done[1]);
  endtask

  task automatic end_checks(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s done_count%0d", tag, i), 32'(act_done[i]), 32'(exp_done[i]));
      check($sformatf("%s write_count%0d", tag, i), 32'(act_wr[i]), 32'(exp_wr[i]));
      check($sformatf("%s frame_error%0d", tag, i), 32'(frame_error[i]), 32'(m_err[i]));
      check($sformatf("%s busy%0d", tag, i), 32'(busy[i]), 32'(m_wait[i] | m_cap[i]));
      check($sformatf("%s pending%0d", tag, i), 32'(q_size(i)), 32'd0);
    end
  endtask

  initial begin
    int w0, w1;
    pw  = '{W0, W1};
    ph  = '{H0, H1};
    pxo = '{XO0, XO1};
    pyo = '{YO0, YO1};
    vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255};
    vecs[1] = '{8'd4,   8'd0,   8'd0,   8'd1};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd0};
    vecs[3] = '{8'd0,   8'd255, 8'd0,   8'd127};
    vecs[4] = '{8'd255, 8'd0,   8'd255, 8'd127};
    vecs[5] = '{8'd3,   8'd0,   8'd0,   8'd0};
    vecs[6] = '{8'd1,   8'd1,   8'd1,   8'd1};
    vecs[7] = '{8'd10,  8'd20,  8'd30,  8'd20};

    // Reset state
    repeat (3) @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset wr_en%0d", i), 32'(wr_en[i]), 32'd0);
      check($sformatf("reset wr_address%0d", i), 32'(wr_address[i]), 32'd0);
      check($sformatf("reset wr_data%0d", i), 32'(wr_data[i]), 32'd0);
      check($sformatf("reset busy%0d", i), 32'(busy[i]), 32'd0);
      check($sformatf("reset done%0d", i), 32'(done[i]), 32'd0);
      check($sformatf("reset frame_error%0d", i), 32'(frame_error[i]), 32'd0);
    end
    reset = 1'b0;
    mon_on = 1'b1;
    idle(4);

    // Full frame with pixel = (px, ln, 0)
    pulse_arm();
    check("arm busy0", 32'(busy[0]), 32'd1);
    check("arm busy1", 32'(busy[1]), 32'd1);
    w0 = act_wr[0];
    w1 = act_wr[1];
    drive_frame(12, 1, -1, -1);
    idle(6);
    check("full frame writes0", 32'(act_wr[0] - w0), 32'(W0 * H0));
    check("full frame writes1", 32'(act_wr[1] - w1), 32'(W1 * H1));
    end_checks("full");

    // Table-driven grayscale vectors on line 0 of window 0
    for (int k = 0; k < NVEC; k++) got0[k] = 8'hxx;
    pulse_arm();
    drive_frame(12, 2, -1, -1);
    idle(6);
    for (int k = 0; k < NVEC; k++) begin
      check($sformatf("gray vec%0d (%0d,%0d,%0d)", k, vecs[k].r, vecs[k].g, vecs[k].b),
            32'(got0[k]), 32'(vecs[k].exp));
    end
    end_checks("table");

    // Random frames; arm during capture in some of them must be ignored
    for (int f = 0; f < 3; f++) begin
      pulse_arm();
      drive_frame(12, 0, (f == 1) ? 2 : -1, -1);
      idle(6);
      end_checks($sformatf("rand%0d", f));
    end

    // Unarmed frame: nothing may be written
    drive_frame(12, 0, -1, -1);
    idle(6);
    end_checks("unarmed");

    // Short frame ends on vsync: error, then cleared by a new arm
    pulse_arm();
    drive_frame(6, 0, -1, -1);
    drive_vsync();
    idle(6);
    check("short frame_error0", 32'(frame_error[0]), 32'd1);
    end_checks("short");
    pulse_arm();
    idle(2);
    check("rearm frame_error0", 32'(frame_error[0]), 32'd0);
    end_checks("rearm");
    drive_frame(12, 0, -1, -1);
    idle(6);
    end_checks("after_rearm");

    // Reset in the middle of line 3 of the window
    pulse_arm();
    drive_frame(12, 0, -1, 3);
    idle(6);
    end_checks("reset_abort");
    pulse_arm();
    drive_frame(12, 0, -1, -1);
    idle(6);
    end_checks("recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
